pwm_multi_ch: RTL and testbench

- Multi-channel PWM generator; next generation of the 8-channel/8-bit PWM. Runs on a single clock; the separate data and counter clocks are gone.
- Channel count, duty width and prescaler width are parameters. Adds a programmable period, a prescaler and double-buffered duty registers (glitch-free updates at the period boundary).
- Adds one-shot/continuous modes, per-channel output polarity, and a period-boundary tick for the downstream LED/display drivers.

---
 rtl/pwm_multi_ch.sv | 162 ++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with programmable period, prescaler and
// double-buffered duty registers that commit only at period boundaries.
module pwm_multi_ch #(
   parameter int CH     = 8,
   parameter int DWIDTH = 8,
   parameter int PSC_W  = 8,
   localparam int LCW   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [DWIDTH-1:0] period,
   input  logic [PSC_W-1:0]  prescale,
   input  logic [CH-1:0]     invert,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [LCW-1:0]    load_ch,
   input  logic [DWIDTH-1:0] load_duty,
   output logic [CH-1:0]     out,
   output logic              busy,
   output logic              period_tick
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] STOPPING = 2'd2;
   localparam logic [LCW:0] CH_L   = (LCW + 1)'(CH);

   logic [1:0]        state_q, state_d;
   logic [DWIDTH-1:0] cnt_q, cnt_d;
   logic [DWIDTH-1:0] period_q, period_d;
   logic [PSC_W-1:0]  psc_q, psc_d;
   logic [PSC_W-1:0]  prescale_q, prescale_d;
   logic              cont_q, cont_d;
   logic              busy_q, busy_d;
   logic [CH-1:0]     out_q, out_d;
   logic [DWIDTH-1:0] shadow_q [CH];
   logic [DWIDTH-1:0] shadow_d [CH];
   logic [DWIDTH-1:0] active_q [CH];
   logic [DWIDTH-1:0] active_d [CH];

   logic wr_ok_s;
   logic tick_s;
   logic boundary_s;
   logic commit_s;

   assign wr_ok_s    = load_valid && ({1'b0, load_ch} < CH_L);
   assign tick_s     = busy_q && (psc_q == prescale_q);
   assign boundary_s = tick_s && (cnt_q == period_q);

   assign load_ready  = 1'b1;
   assign out         = out_q;
   assign busy        = busy_q;
   assign period_tick = boundary_s;

   // Next-state logic: FSM, prescaler, counter, duty buffering and outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      psc_d      = psc_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      cont_d     = cont_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      commit_s   = 1'b0;

      if (wr_ok_s) begin
         shadow_d[load_ch] = load_duty;
      end else begin
         shadow_d = shadow_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               cnt_d      = '0;
               psc_d      = '0;
               period_d   = period;
               prescale_d = prescale;
               cont_d     = continuous;
               commit_s   = 1'b1;
            end else begin
               psc_d = '0;
            end
         end
         RUN, STOPPING: begin
            psc_d = tick_s ? '0 : psc_q + 1'b1;
            if (state_q == RUN && stop) begin
               state_d = STOPPING;
            end else begin
               state_d = state_q;
            end
            // A stop on the boundary cycle still lets one more period run.
            if (boundary_s) begin
               cnt_d = '0;
               if (state_q == STOPPING || !cont_q) begin
                  state_d = IDLE;
               end else begin
                  period_d = period;
                  commit_s = 1'b1;
               end
            end else if (tick_s) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit_s) begin
         active_d = shadow_d;
      end else begin
         active_d = active_q;
      end

      busy_d = (state_d != IDLE);
      for (int i = 0; i < CH; i++) begin
         if (busy_d) begin
            out_d[i] = (cnt_d < active_d[i]) ^ invert[i];
         end else begin
            out_d[i] = invert[i];
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         psc_q      <= '0;
         period_q   <= '0;
         prescale_q <= '0;
         cont_q     <= 1'b0;
         busy_q     <= 1'b0;
         out_q      <= '0;
         for (int i = 0; i < CH; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         psc_q      <= psc_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         cont_q     <= cont_d;
         busy_q     <= busy_d;
         out_q      <= out_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
      end
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: stimulus queues per-period expectations,
// a monitor measures each period at period_tick and compares.
module tb_pwm_multi_ch;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, continuous, load_valid;
   logic       load_ready, busy, period_tick;
   logic [7:0] period, prescale, invert, load_duty, out;
   logic [2:0] load_ch;
   logic [4:0] out_o;
   logic       ready_o, busy_o, tick_o;

   int total  = 0;
   int passed = 0;

   int               q_cyc [$];
   bit               q_more[$];
   logic [7:0][15:0] q_act [$];
   int               ea [8];

   pwm_multi_ch #(.CH(8), .DWIDTH(8), .PSC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .period(period), .prescale(prescale), .invert(invert),
      .load_valid(load_valid), .load_ready(load_ready), .load_ch(load_ch),
      .load_duty(load_duty), .out(out), .busy(busy), .period_tick(period_tick)
   );

   // Five channels: load_ch values 5..7 must be dropped
   pwm_multi_ch #(.CH(5), .DWIDTH(8), .PSC_W(8)) dut_odd (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .period(period), .prescale(prescale), .invert(invert[4:0]),
      .load_valid(load_valid), .load_ready(ready_o), .load_ch(load_ch),
      .load_duty(load_duty), .out(out_o), .busy(busy_o), .period_tick(tick_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int cycles, input bit more);
      logic [7:0][15:0] v;
      for (int i = 0; i < 8; i++) v[i] = 16'(ea[i]);
      q_cyc.push_back(cycles);
      q_act.push_back(v);
      q_more.push_back(more);
   endtask

   task automatic load(input int ch, input int duty);
      load_valid = 1'b1;
      load_ch    = 3'(ch);
      load_duty  = 8'(duty);
      cyc();
      load_valid = 1'b0;
   endtask

   task automatic go(input int per, input int psc, input bit cont);
      period     = 8'(per);
      prescale   = 8'(psc);
      continuous = cont;
      start      = 1'b1;
      cyc();
      start      = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         cyc();
         n++;
      end
      chk("run_ends", busy, 1'b0);
      cyc();
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!period_tick && n < 3000) begin
         cyc();
         n++;
      end
      chk("tick_seen", period_tick, 1'b1);
   endtask

   // Monitor: accumulate active cycles per period, compare at each period_tick
   initial begin
      int               acc_cyc;
      int               acc [8];
      bit               pend, exp_busy;
      logic [7:0][15:0] got;
      acc_cyc = 0;
      pend    = 1'b0;
      exp_busy = 1'b0;
      for (int i = 0; i < 8; i++) acc[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_cyc = 0;
            pend    = 1'b0;
            for (int i = 0; i < 8; i++) acc[i] = 0;
         end else begin
            if (pend) begin
               chk("busy_after_period", busy, exp_busy);
               pend = 1'b0;
            end
            if (busy) begin
               acc_cyc++;
               for (int i = 0; i < 8; i++) acc[i] += int'(out[i] ^ invert[i]);
               if (period_tick) begin
                  if (q_cyc.size() == 0) begin
                     chk("unexpected_period", 1'b1, 1'b0);
                  end else begin
                     for (int i = 0; i < 8; i++) got[i] = 16'(acc[i]);
                     chk("period_cycles", acc_cyc, q_cyc.pop_front());
                     chk("period_active", got, q_act.pop_front());
                     exp_busy = q_more.pop_front();
                     pend     = 1'b1;
                  end
                  acc_cyc = 0;
                  for (int i = 0; i < 8; i++) acc[i] = 0;
               end
            end else begin
               chk("tick_while_idle", period_tick, 1'b0);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      period = 8'd0; prescale = 8'd0; invert = 8'h00;
      load_valid = 1'b0; load_ch = 3'd0; load_duty = 8'd0;
      #2;
      chk("reset_out", out, 8'h00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_tick", period_tick, 1'b0);
      chk("load_ready", load_ready, 1'b1);
      #10 rst_n = 1'b1;
      cyc();

      // 1: one-shot, full 8-bit period, assorted duties
      ea = '{0, 1, 2, 64, 128, 254, 255, 7};
      for (int i = 0; i < 8; i++) load(i, ea[i]);
      push(256, 1'b0);
      go(255, 0, 1'b0);
      chk("run_busy", busy, 1'b1);
      wait_idle();

      // 2: prescaler 3, period 9, duty beyond period saturates
      for (int i = 0; i < 8; i++) load(i, 0);
      load(0, 4);
      load(1, 12);
      ea = '{16, 40, 0, 0, 0, 0, 0, 0};
      push(40, 1'b1);
      push(40, 1'b0);
      go(9, 3, 1'b1);
      repeat (50) cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      wait_idle();

      // 3: double buffering, mid-period write and boundary-edge write
      load(1, 0);
      load(0, 4);
      ea = '{4, 0, 0, 0, 0, 0, 0, 0};  push(16, 1'b1);
      ea = '{8, 0, 0, 0, 0, 0, 0, 0};  push(16, 1'b1);
      ea = '{2, 0, 0, 0, 0, 0, 0, 0};  push(16, 1'b0);
      go(15, 0, 1'b1);
      repeat (5) cyc();
      load(0, 8);
      wait_tick();
      cyc();
      wait_tick();
      load(0, 2);
      repeat (2) cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      wait_idle();

      // 4: polarity
      invert = 8'h81;
      load(0, 0);
      chk("idle_invert", out, 8'h81);
      ea = '{0, 0, 0, 0, 0, 0, 0, 0};
      push(8, 1'b0);
      go(7, 0, 1'b0);
      chk("run_invert_zero_duty", out, 8'h81);
      wait_idle();
      chk("idle_invert_after", out, 8'h81);
      load(0, 3);
      ea = '{3, 0, 0, 0, 0, 0, 0, 0};
      push(8, 1'b0);
      go(7, 0, 1'b0);
      chk("run_invert_active_low", out, 8'h80);
      wait_idle();
      chk("idle_invert_end", out, 8'h81);
      invert = 8'h00;

      // 5: stop mid-period, start while busy, start+stop together in IDLE
      load(0, 6);
      ea = '{6, 0, 0, 0, 0, 0, 0, 0};
      push(16, 1'b0);
      go(15, 0, 1'b1);
      repeat (5) cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      repeat (2) cyc();
      continuous = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      wait_idle();
      chk("out_back_to_invert", out, 8'h00);
      ea = '{4, 0, 0, 0, 0, 0, 0, 0};
      push(4, 1'b1);
      push(4, 1'b0);
      stop = 1'b1;
      go(3, 0, 1'b1);
      stop = 1'b0;
      repeat (5) cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      wait_idle();

      // 6: asynchronous reset mid-run, then out-of-range channel write
      for (int i = 0; i < 8; i++) load(i, 10);
      invert = 8'h00;
      go(15, 0, 1'b1);
      repeat (7) cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", out, 8'h00);
      chk("async_reset_busy", busy, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      cyc();
      ea = '{0, 0, 0, 0, 0, 0, 0, 0};
      push(4, 1'b0);
      go(3, 0, 1'b0);
      wait_idle();
      load(6, 200);
      load(2, 200);
      ea = '{0, 0, 4, 0, 0, 0, 4, 0};
      push(4, 1'b0);
      go(3, 0, 1'b0);
      chk("odd_ch_drop_write", out_o, 5'b00100);
      chk("odd_ch_busy", busy_o, 1'b1);
      wait_idle();

      repeat (2) cyc();
      chk("scoreboard_drained", q_cyc.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
